fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the decode stage.
- Holds the PC and reads 16-bit words from the instruction memory.
- Assembles one-word and two-word (immediate-carrying) instructions and presents opcode/src/dst/imm/next-PC to decode.
- Honours stall (hazard unit), flush (decode control unit) and redirect (branch resolution).

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Processor-wide instruction format constants and fetch FSM encoding.
// Shared by the fetch stage and its IF/ID register.
package fetch_stage_pkg;

  localparam int OPC_HI       = 15;
  localparam int OPC_LO       = 10;
  localparam int SRC_HI       = 9;
  localparam int SRC_LO       = 7;
  localparam int DST_HI       = 6;
  localparam int DST_LO       = 4;
  localparam int FUNC_HI      = 3;
  localparam int FUNC_LO      = 0;
  localparam int TWO_WORD_BIT = 5;

  localparam logic [5:0] NOP_OPC = 6'b0;

  typedef enum logic {
    FETCH     = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_e;

  // The two-word marker is bit 5 of the opcode field.
  function automatic logic is_two_word(input logic [15:0] word);
    return word[OPC_LO + TWO_WORD_BIT];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble clears it, hold freezes it, load captures
// a new instruction. Bubble wins over hold, and hold wins over load.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          bubble,
  input  logic          hold,
  input  logic          vld_p0,
  input  logic [5:0]    opcode_p0,
  input  logic [2:0]    src_p0,
  input  logic [2:0]    dst_p0,
  input  logic [3:0]    func_p0,
  input  logic [W-1:0]  imm_p0,
  input  logic [AW-1:0] pc_next_p0,
  output logic          vld_p1,
  output logic [5:0]    opcode_p1,
  output logic [2:0]    src_p1,
  output logic [2:0]    dst_p1,
  output logic [3:0]    func_p1,
  output logic [W-1:0]  imm_p1,
  output logic [AW-1:0] pc_next_p1
);

  // p0 -> p1: IF/ID boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= NOP_OPC;
      src_p1     <= '0;
      dst_p1     <= '0;
      func_p1    <= '0;
      imm_p1     <= '0;
      pc_next_p1 <= '0;
    end else if (bubble) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= NOP_OPC;
      src_p1     <= '0;
      dst_p1     <= '0;
      func_p1    <= '0;
      imm_p1     <= '0;
      pc_next_p1 <= '0;
    end else if (!hold && load) begin
      vld_p1     <= vld_p0;
      opcode_p1  <= opcode_p0;
      src_p1     <= src_p0;
      dst_p1     <= dst_p0;
      func_p1    <= func_p0;
      imm_p1     <= imm_p0;
      pc_next_p1 <= pc_next_p0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one/two-word assembly FSM and hold register,
// feeding the IF/ID register that drives decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              W        = 16,
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [W-1:0]  imem_data,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  output logic          ifid_valid,
  output logic [5:0]    ifid_opcode,
  output logic [2:0]    ifid_src,
  output logic [2:0]    ifid_dst,
  output logic [3:0]    ifid_func,
  output logic [W-1:0]  ifid_imm,
  output logic [AW-1:0] ifid_pc_next
);

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  logic [AW-1:0] pc_p0;
  fetch_state_e  state_p0;
  logic [W-1:0]  hold_p0;

  logic          load, bubble, hold_ifid;
  logic          vld_p0;
  logic [W-1:0]  word_p0;
  logic [W-1:0]  imm_p0;
  logic [AW-1:0] pc_next_p0;
  logic          first_two_word;

  assign imem_addr      = pc_p0;
  assign first_two_word = is_two_word(imem_data);

  assign word_p0    = (state_p0 == FETCH_IMM) ? hold_p0 : imem_data;
  assign imm_p0     = (state_p0 == FETCH_IMM) ? imem_data : '0;
  assign pc_next_p0 = pc_inc(pc_p0);
  assign vld_p0     = 1'b1;

  always_comb begin
    load      = 1'b0;
    bubble    = 1'b0;
    hold_ifid = 1'b0;
    if (redirect_en || flush) begin
      bubble = 1'b1;
    end else if (stall) begin
      hold_ifid = 1'b1;
    end else if (state_p0 == FETCH && first_two_word) begin
      bubble = 1'b1;
    end else begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0    <= RESET_PC;
      state_p0 <= FETCH;
      hold_p0  <= '0;
    end else if (redirect_en) begin
      pc_p0    <= redirect_pc;
      state_p0 <= FETCH;
      hold_p0  <= '0;
    end else if (!flush && !stall) begin
      pc_p0 <= pc_inc(pc_p0);
      case (state_p0)
        FETCH: begin
          if (first_two_word) begin
            hold_p0  <= imem_data;
            state_p0 <= FETCH_IMM;
          end
        end
        FETCH_IMM: state_p0 <= FETCH;
        default:   state_p0 <= FETCH;
      endcase
    end
  end

  if_id_reg #(.W(W), .AW(AW)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bubble     (bubble),
    .hold       (hold_ifid),
    .vld_p0     (vld_p0),
    .opcode_p0  (word_p0[OPC_HI:OPC_LO]),
    .src_p0     (word_p0[SRC_HI:SRC_LO]),
    .dst_p0     (word_p0[DST_HI:DST_LO]),
    .func_p0    (word_p0[FUNC_HI:FUNC_LO]),
    .imm_p0     (imm_p0),
    .pc_next_p0 (pc_next_p0),
    .vld_p1     (ifid_valid),
    .opcode_p1  (ifid_opcode),
    .src_p1     (ifid_src),
    .dst_p1     (ifid_dst),
    .func_p1    (ifid_func),
    .imm_p1     (ifid_imm),
    .pc_next_p1 (ifid_pc_next)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one main instance at RESET_PC=0 and a
// second at RESET_PC=16'hFFFF for address wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_w = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect_en = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] mem [0:65535];

  logic [15:0] imem_addr, imem_data, ifid_imm, ifid_pc_next;
  logic        ifid_valid;
  logic [5:0]  ifid_opcode;
  logic [2:0]  ifid_src, ifid_dst;
  logic [3:0]  ifid_func;

  logic [15:0] w_addr, w_data, w_imm, w_pc_next;
  logic        w_valid;
  logic [5:0]  w_opcode;
  logic [2:0]  w_src, w_dst;
  logic [3:0]  w_func;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];
  assign w_data    = mem[w_addr];

  fetch_stage #(.W(16), .AW(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode), .ifid_src(ifid_src),
    .ifid_dst(ifid_dst), .ifid_func(ifid_func), .ifid_imm(ifid_imm),
    .ifid_pc_next(ifid_pc_next)
  );

  fetch_stage #(.W(16), .AW(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(w_addr), .imem_data(w_data),
    .stall(stall), .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .ifid_valid(w_valid), .ifid_opcode(w_opcode), .ifid_src(w_src),
    .ifid_dst(w_dst), .ifid_func(w_func), .ifid_imm(w_imm),
    .ifid_pc_next(w_pc_next)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst low one edge and returns 1ns after a rising edge.
  task automatic enter_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[16'hFFFF] = 16'h0000;
    cyc();
  endtask

  task automatic test_reset();
    enter_reset();
    n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    n_tests++; if ({ifid_opcode, ifid_src, ifid_dst, ifid_func} !== 16'h0000) begin n_fail++; $display("FAIL reset_fields: got %h want 0000", {ifid_opcode, ifid_src, ifid_dst, ifid_func}); end
    n_tests++; if ({ifid_imm, ifid_pc_next} !== 32'h0) begin n_fail++; $display("FAIL reset_imm_pc: got %h want 0", {ifid_imm, ifid_pc_next}); end
  endtask

  task automatic test_one_word();
    enter_reset();
    mem[0] = 16'h0A54; mem[1] = 16'h0C21;
    rst = 1'b1;
    cyc();
    n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL ow_valid: got %b want 1", ifid_valid); end
    n_tests++; if ({ifid_opcode, ifid_src, ifid_dst, ifid_func} !== {6'd2, 3'd4, 3'd5, 4'd4}) begin n_fail++; $display("FAIL ow_fields: got %h/%h/%h/%h want 2/4/5/4", ifid_opcode, ifid_src, ifid_dst, ifid_func); end
    n_tests++; if (ifid_imm !== 16'h0000 || ifid_pc_next !== 16'h0001) begin n_fail++; $display("FAIL ow_imm_pc: got %h/%h want 0000/0001", ifid_imm, ifid_pc_next); end
    n_tests++; if (imem_addr !== 16'h0001) begin n_fail++; $display("FAIL ow_addr: got %h want 0001", imem_addr); end
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'd3 || ifid_pc_next !== 16'h0002) begin n_fail++; $display("FAIL ow_second: got v=%b op=%h pcn=%h want 1/03/0002", ifid_valid, ifid_opcode, ifid_pc_next); end
  endtask

  task automatic test_two_word();
    enter_reset();
    mem[0] = 16'h8123; mem[1] = 16'hBEEF;
    rst = 1'b1;
    cyc();
    n_tests++; if (ifid_valid !== 1'b0 || imem_addr !== 16'h0001) begin n_fail++; $display("FAIL tw_bubble: got v=%b addr=%h want 0/0001", ifid_valid, imem_addr); end
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'h20) begin n_fail++; $display("FAIL tw_op: got v=%b op=%h want 1/20", ifid_valid, ifid_opcode); end
    n_tests++; if ({ifid_src, ifid_dst, ifid_func} !== {3'd2, 3'd2, 4'd3}) begin n_fail++; $display("FAIL tw_fields: got %h/%h/%h want 2/2/3", ifid_src, ifid_dst, ifid_func); end
    n_tests++; if (ifid_imm !== 16'hBEEF || ifid_pc_next !== 16'h0002 || imem_addr !== 16'h0002) begin n_fail++; $display("FAIL tw_imm_pc: got %h/%h/%h want BEEF/0002/0002", ifid_imm, ifid_pc_next, imem_addr); end
  endtask

  task automatic test_stall();
    enter_reset();
    mem[0] = 16'h8456; mem[1] = 16'h1234; mem[2] = 16'h0A54;
    rst = 1'b1;
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++; if (imem_addr !== 16'h0001 || ifid_valid !== 1'b0 || ifid_opcode !== 6'h00) begin n_fail++; $display("FAIL stall_frozen[%0d]: got addr=%h v=%b op=%h want 0001/0/00", i, imem_addr, ifid_valid, ifid_opcode); end
    end
    stall = 1'b0;
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'h21 || ifid_imm !== 16'h1234 || ifid_pc_next !== 16'h0002) begin n_fail++; $display("FAIL stall_done: got v=%b op=%h imm=%h pcn=%h want 1/21/1234/0002", ifid_valid, ifid_opcode, ifid_imm, ifid_pc_next); end
    stall = 1'b1;
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_imm !== 16'h1234 || imem_addr !== 16'h0002) begin n_fail++; $display("FAIL stall_hold_valid: got v=%b imm=%h addr=%h want 1/1234/0002", ifid_valid, ifid_imm, imem_addr); end
    stall = 1'b0;
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'd2 || ifid_pc_next !== 16'h0003) begin n_fail++; $display("FAIL stall_next: got v=%b op=%h pcn=%h want 1/02/0003", ifid_valid, ifid_opcode, ifid_pc_next); end
  endtask

  task automatic test_flush();
    enter_reset();
    for (int i = 0; i < 5; i++) mem[i] = 16'h0400 | 16'(i);
    mem[5] = 16'h0C21;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    n_tests++; if (imem_addr !== 16'h0005 || ifid_pc_next !== 16'h0005) begin n_fail++; $display("FAIL flush_pre: got addr=%h pcn=%h want 0005/0005", imem_addr, ifid_pc_next); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_tests++; if (ifid_valid !== 1'b0 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL flush_bubble: got v=%b addr=%h want 0/0005", ifid_valid, imem_addr); end
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'd3 || ifid_pc_next !== 16'h0006) begin n_fail++; $display("FAIL flush_refetch: got v=%b op=%h pcn=%h want 1/03/0006", ifid_valid, ifid_opcode, ifid_pc_next); end
  endtask

  task automatic test_redirect();
    enter_reset();
    mem[0] = 16'h8123; mem[1] = 16'hBEEF; mem[16'h40] = 16'h0C21;
    rst = 1'b1;
    cyc();
    redirect_en = 1'b1; redirect_pc = 16'h0040; stall = 1'b1; flush = 1'b1;
    cyc();
    redirect_en = 1'b0; stall = 1'b0; flush = 1'b0;
    n_tests++; if (imem_addr !== 16'h0040 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got addr=%h v=%b want 0040/0", imem_addr, ifid_valid); end
    cyc();
    n_tests++; if (ifid_valid !== 1'b1 || ifid_opcode !== 6'd3 || ifid_imm !== 16'h0000 || ifid_pc_next !== 16'h0041) begin n_fail++; $display("FAIL redir_target: got v=%b op=%h imm=%h pcn=%h want 1/03/0000/0041", ifid_valid, ifid_opcode, ifid_imm, ifid_pc_next); end
  endtask

  task automatic test_wrap();
    rst_w = 1'b0;
    mem[16'hFFFF] = 16'h8123; mem[0] = 16'h5A5A; mem[1] = 16'h0000;
    cyc();
    n_tests++; if (w_addr !== 16'hFFFF || w_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_reset: got addr=%h v=%b want FFFF/0", w_addr, w_valid); end
    rst_w = 1'b1;
    cyc();
    n_tests++; if (w_addr !== 16'h0000 || w_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_mid: got addr=%h v=%b want 0000/0", w_addr, w_valid); end
    cyc();
    n_tests++; if (w_valid !== 1'b1 || w_opcode !== 6'h20 || w_imm !== 16'h5A5A || w_pc_next !== 16'h0001) begin n_fail++; $display("FAIL wrap_done: got v=%b op=%h imm=%h pcn=%h want 1/20/5A5A/0001", w_valid, w_opcode, w_imm, w_pc_next); end
    // Restart, then pull reset between word0 and the immediate.
    rst_w = 1'b0;
    cyc();
    rst_w = 1'b1;
    cyc();
    n_tests++; if (w_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_restart: got addr=%h want 0000", w_addr); end
    #2 rst_w = 1'b0;
    #1;
    n_tests++; if (w_addr !== 16'hFFFF || w_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_async: got addr=%h v=%b want FFFF/0", w_addr, w_valid); end
    cyc();
    rst_w = 1'b1;
    cyc();
    n_tests++; if (w_valid !== 1'b0 || w_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_after_rst1: got v=%b addr=%h want 0/0000", w_valid, w_addr); end
    cyc();
    n_tests++; if (w_valid !== 1'b1 || w_opcode !== 6'h20 || w_imm !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_after_rst2: got v=%b op=%h imm=%h want 1/20/5A5A", w_valid, w_opcode, w_imm); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    #2;
    test_reset();
    test_one_word();
    test_two_word();
    test_stall();
    test_flush();
    test_redirect();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
